// File: rtl/skinny_masked_pkg.sv
// Constants and helpers for the two-share masked SKINNY inverse S-box.
// The unmasked helpers describe the datapath layers and check them against the table.
package skinny_masked_pkg;

    localparam int SHARE_W    = 4;
    localparam int NUM_LAYERS = 4;

    typedef logic [SHARE_W-1:0] nib_t;

    // Inverse S-box, entry v in bits [4v+3:4v].
    localparam logic [63:0] INV_SBOX = 64'hfdb0_7529_e1ac_8643;

    // Every layer does x0 ^= NOR(x3, x2); only the trailing permutation differs.
    // Each permutation byte holds, per output bit i, the 2-bit source index in [2i+1:2i].
    // Layers 0..2 rotate right by one bit, and layer 3 is the identity.
    localparam int          LAYER_J    = 0;
    localparam int          LAYER_P    = 3;
    localparam int          LAYER_Q    = 2;
    localparam logic [31:0] LAYER_PERM = 32'he4_39_39_39;

    function automatic nib_t permute(input nib_t x, input int layer);
        nib_t y;
        for (int i = 0; i < SHARE_W; i++)
            y[i] = x[LAYER_PERM[8*layer + 2*i +: 2]];
        return y;
    endfunction

    // Completes one layer on a single share, once that share's AND output is known.
    function automatic nib_t finish_layer(input nib_t s, input logic z, input int layer);
        nib_t t;
        t = s;
        t[LAYER_J] = t[LAYER_J] ^ z;
        return permute(t, layer);
    endfunction

    function automatic nib_t inv_sbox_unmasked(input nib_t x);
        nib_t t;
        t = x;
        for (int l = 0; l < NUM_LAYERS; l++) begin
            t[LAYER_J] = t[LAYER_J] ^ ~(t[LAYER_P] | t[LAYER_Q]);
            t = permute(t, l);
        end
        return t;
    endfunction

endpackage

// File: rtl/skinny_dom_and.sv
// Two-share domain-oriented AND gate with a registered output.
// Cross-domain terms are refreshed with one random bit before they are registered.
module skinny_dom_and (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic a0,
    input  logic a1,
    input  logic b0,
    input  logic b1,
    input  logic r,
    output logic z0,
    output logic z1
);

    logic inner0_q;
    logic inner1_q;
    logic cross0_q;
    logic cross1_q;

    // Terms are held separately so the two domains only merge after the register.
    always_ff @(posedge clk) begin
        if (rst) begin
            inner0_q <= 1'b0;
            inner1_q <= 1'b0;
            cross0_q <= 1'b0;
            cross1_q <= 1'b0;
        end else if (en) begin
            inner0_q <= a0 & b0;
            cross0_q <= (a0 & b1) ^ r;
            cross1_q <= (a1 & b0) ^ r;
            inner1_q <= a1 & b1;
        end
    end

    assign z0 = inner0_q ^ cross0_q;
    assign z1 = inner1_q ^ cross1_q;

endmodule

// File: rtl/skinny_inv_sbox_masked.sv
// Four-stage masked SKINNY inverse S-box pipeline with valid/ready backpressure.
// There is one NOR-XOR layer per stage, and an output register is added when OUT_REG=1.
module skinny_inv_sbox_masked
    import skinny_masked_pkg::*;
#(
    parameter int OUT_REG = 0,
    parameter int RND_W   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_sh0,
    input  logic [3:0]       in_sh1,
    input  logic [RND_W-1:0] rnd,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_sh0,
    output logic [3:0]       out_sh1
);

    if (RND_W != NUM_LAYERS) begin : g_bad_rnd_w
        $error("skinny_inv_sbox_masked: RND_W must be 4");
    end

    for (genvar v = 0; v < 16; v++) begin : g_table_check
        if (inv_sbox_unmasked(nib_t'(v)) != INV_SBOX[4*v +: 4]) begin : g_bad_layers
            $error("skinny_inv_sbox_masked: layer constants do not compose to the inverse S-box");
        end
    end

    logic [NUM_LAYERS-1:0] vld;
    logic [NUM_LAYERS-1:0] v_in;
    logic [NUM_LAYERS-1:0] ld;
    logic [NUM_LAYERS-1:0] en;
    logic [NUM_LAYERS-1:0] r_use;
    logic [NUM_LAYERS-1:0] z0;
    logic [NUM_LAYERS-1:0] z1;
    logic                  adv_out;

    nib_t [NUM_LAYERS:0]   s0_in;
    nib_t [NUM_LAYERS:0]   s1_in;
    nib_t [NUM_LAYERS-1:0] sh0_q;
    nib_t [NUM_LAYERS-1:0] sh1_q;

    logic [2:0] rnd_q0;
    logic [1:0] rnd_q1;
    logic       rnd_q2;

    assign v_in     = {vld[NUM_LAYERS-2:0], in_valid};
    assign s0_in[0] = in_sh0;
    assign s1_in[0] = in_sh1;
    assign r_use    = {rnd_q2, rnd_q1[0], rnd_q0[0], rnd[0]};

    // A stage may load if it or any later stage has room; this ready chain is fully combinational.
    for (genvar k = 0; k < NUM_LAYERS; k++) begin : g_ready
        assign ld[k] = adv_out || !(&vld[NUM_LAYERS-1:k]);
    end

    assign en       = ld & v_in;
    assign in_ready = ld[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            vld   <= '0;
            sh0_q <= '0;
            sh1_q <= '0;
        end else begin
            for (int k = 0; k < NUM_LAYERS; k++) begin
                if (ld[k])
                    vld[k] <= v_in[k];
                if (en[k]) begin
                    sh0_q[k] <= s0_in[k];
                    sh1_q[k] <= s1_in[k];
                end
            end
        end
    end

    // Unused random bits ride along with their item and shrink by one bit per stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            rnd_q0 <= '0;
            rnd_q1 <= '0;
            rnd_q2 <= 1'b0;
        end else begin
            if (en[0])
                rnd_q0 <= rnd[3:1];
            if (en[1])
                rnd_q1 <= rnd_q0[2:1];
            if (en[2])
                rnd_q2 <= rnd_q1[1];
        end
    end

    // NOR(x3, x2) = ~x3 & ~x2, and the complement is applied to share 0 only.
    for (genvar k = 0; k < NUM_LAYERS; k++) begin : g_layer
        skinny_dom_and u_dom_and (
            .clk (clk),
            .rst (rst),
            .en  (en[k]),
            .a0  (~s0_in[k][LAYER_P]),
            .a1  (s1_in[k][LAYER_P]),
            .b0  (~s0_in[k][LAYER_Q]),
            .b1  (s1_in[k][LAYER_Q]),
            .r   (r_use[k]),
            .z0  (z0[k]),
            .z1  (z1[k])
        );

        assign s0_in[k+1] = finish_layer(sh0_q[k], z0[k], k);
        assign s1_in[k+1] = finish_layer(sh1_q[k], z1[k], k);
    end

    if (OUT_REG != 0) begin : g_out_reg
        logic ov_q;
        nib_t o0_q;
        nib_t o1_q;

        assign adv_out = !ov_q || out_ready;

        always_ff @(posedge clk) begin
            if (rst) begin
                ov_q <= 1'b0;
                o0_q <= '0;
                o1_q <= '0;
            end else begin
                if (adv_out)
                    ov_q <= vld[NUM_LAYERS-1];
                if (adv_out && vld[NUM_LAYERS-1]) begin
                    o0_q <= s0_in[NUM_LAYERS];
                    o1_q <= s1_in[NUM_LAYERS];
                end
            end
        end

        assign out_valid = ov_q;
        assign out_sh0   = o0_q;
        assign out_sh1   = o1_q;
    end else begin : g_out_comb
        assign adv_out   = out_ready;
        assign out_valid = vld[NUM_LAYERS-1];
        assign out_sh0   = s0_in[NUM_LAYERS];
        assign out_sh1   = s1_in[NUM_LAYERS];
    end

endmodule

// File: tb/tb_skinny_inv_sbox_masked.sv
// Self-checking bench for skinny_inv_sbox_masked.
// It uses a table-driven scoreboard and randomised shares and randomness.
module tb_skinny_inv_sbox_masked;

    localparam int OUT_REG = 0;
    localparam int RND_W   = 4;
    localparam int LAT     = 4 + OUT_REG;

    localparam logic [3:0] INV_TAB [16] = '{4'h3, 4'h4, 4'h6, 4'h8, 4'hc, 4'ha, 4'h1, 4'he,
                                            4'h9, 4'h2, 4'h5, 4'h7, 4'h0, 4'hb, 4'hd, 4'hf};

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       in_sh0;
    logic [3:0]       in_sh1;
    logic [RND_W-1:0] rnd;
    logic             out_valid;
    logic             out_ready;
    logic [3:0]       out_sh0;
    logic [3:0]       out_sh1;

    skinny_inv_sbox_masked #(.OUT_REG(OUT_REG), .RND_W(RND_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sh0    (in_sh0),
        .in_sh1    (in_sh1),
        .rnd       (rnd),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sh0   (out_sh0),
        .out_sh1   (out_sh1)
    );

    always #5 clk = ~clk;

    int         checks   = 0;
    int         errors   = 0;
    int         edge_cnt = 0;
    logic [3:0] q_x [$];
    int         q_t [$];
    bit         lat_chk    = 1'b0;
    bit         track_mask = 1'b0;
    bit         last_acc;
    bit         last_outx;
    logic [3:0] first_sh1 [16];
    bit         seen   [16];
    bit         varied [16];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(input logic [3:0] o0, input logic [3:0] o1);
        logic [3:0] x;
        int         t;
        check("spurious_output", 32'(q_x.size() != 0), 32'd1);
        if (q_x.size() != 0) begin
            x = q_x.pop_front();
            t = q_t.pop_front();
            check("result", 32'(o0 ^ o1), 32'(INV_TAB[x]));
            if (lat_chk)
                check("latency", 32'(edge_cnt - t), 32'(LAT));
            if (track_mask) begin
                if (!seen[x]) begin
                    seen[x]      = 1'b1;
                    first_sh1[x] = o1;
                end else if (o1 != first_sh1[x]) begin
                    varied[x] = 1'b1;
                end
            end
        end
    endtask

    // Starts at a falling edge, samples the handshakes, lets one rising edge pass, then returns at the next falling edge.
    task automatic cycle();
        logic       acc;
        logic       outx;
        logic       in_rst;
        logic [3:0] o0;
        logic [3:0] o1;
        logic [3:0] ix;
        #2;
        in_rst = rst;
        acc    = in_valid && in_ready;
        outx   = out_valid && out_ready;
        o0     = out_sh0;
        o1     = out_sh1;
        ix     = in_sh0 ^ in_sh1;
        @(posedge clk);
        edge_cnt++;
        last_acc  = acc && !in_rst;
        last_outx = outx && !in_rst;
        if (last_acc) begin
            q_x.push_back(ix);
            q_t.push_back(edge_cnt);
        end
        if (last_outx)
            checkOutput(o0, o1);
        @(negedge clk);
    endtask

    task automatic applyStimulus(input logic v, input logic [3:0] x, input logic [3:0] s1,
                                 input logic [RND_W-1:0] r, input logic ordy);
        in_valid  = v;
        in_sh1    = s1;
        in_sh0    = x ^ s1;
        rnd       = r;
        out_ready = ordy;
        cycle();
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (q_x.size() != 0 && n < 50) begin
            applyStimulus(1'b0, 4'h0, 4'h0, '0, 1'b1);
            n++;
        end
        check(tag, 32'(q_x.size()), 32'd0);
    endtask

    initial begin
        int n;
        int cyc;
        int ghost;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_sh0    = '0;
        in_sh1    = '0;
        rnd       = '0;
        out_ready = 1'b0;
        @(negedge clk);
        cycle();
        cycle();
        rst = 1'b0;
        #1;
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_out_sh0", 32'(out_sh0), 32'd0);
        check("reset_out_sh1", 32'(out_sh1), 32'd0);

        $display("[TB] exhaustive sweep");
        lat_chk = 1'b1;
        for (int x = 0; x < 16; x++) begin
            applyStimulus(1'b1, 4'(x), 4'h0, '0, 1'b1);
            check("sweep_accept", 32'(last_acc), 32'd1);
        end
        drain("sweep_drain");

        $display("[TB] masked random run");
        track_mask = 1'b1;
        n   = 0;
        cyc = 0;
        while (n < 10000 && cyc < 20000) begin
            applyStimulus($urandom_range(0, 9) != 0, 4'($urandom), 4'($urandom), 4'($urandom), 1'b1);
            if (last_acc)
                n++;
            cyc++;
        end
        check("masked_count", 32'(n), 32'd10000);
        drain("masked_drain");
        track_mask = 1'b0;
        for (int x = 0; x < 16; x++)
            check("mask_varies", 32'(varied[x]), 32'd1);

        $display("[TB] backpressure");
        lat_chk = 1'b0;
        n = 0;
        for (int i = 1; i <= 6; i++) begin
            applyStimulus(1'b1, 4'($urandom), 4'($urandom), 4'($urandom), 1'b0);
            if (last_acc)
                n++;
            #1;
            check("stall_valid", 32'(out_valid), 32'(i >= LAT));
            if (i >= LAT && q_x.size() != 0)
                check("stall_hold", 32'(out_sh0 ^ out_sh1), 32'(INV_TAB[q_x[0]]));
        end
        check("stall_accepts", 32'(n), 32'(LAT));
        check("stall_in_ready", 32'(in_ready), 32'd0);
        drain("stall_drain");

        $display("[TB] full pipe");
        for (int i = 0; i < LAT; i++)
            applyStimulus(1'b1, 4'($urandom), 4'($urandom), 4'($urandom), 1'b0);
        check("fill_count", 32'(q_x.size()), 32'(LAT));
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 4'($urandom), 4'($urandom), 4'($urandom), 1'b1);
            check("full_in", 32'(last_acc), 32'd1);
            check("full_out", 32'(last_outx), 32'd1);
            check("full_occupancy", 32'(q_x.size()), 32'(LAT));
        end
        drain("full_drain");

        $display("[TB] reset mid-flight");
        lat_chk = 1'b1;
        for (int i = 0; i < 3; i++)
            applyStimulus(1'b1, 4'($urandom), 4'($urandom), 4'($urandom), 1'b1);
        rst = 1'b1;
        applyStimulus(1'b0, 4'h0, 4'h0, '0, 1'b1);
        rst = 1'b0;
        q_x.delete();
        q_t.delete();
        #1;
        check("midreset_out_valid", 32'(out_valid), 32'd0);
        check("midreset_out_sh0", 32'(out_sh0), 32'd0);
        check("midreset_out_sh1", 32'(out_sh1), 32'd0);
        ghost = 0;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 4'h0, 4'h0, '0, 1'b1);
            if (last_outx)
                ghost++;
        end
        check("midreset_no_ghost", 32'(ghost), 32'd0);
        applyStimulus(1'b1, 4'hc, 4'($urandom), 4'($urandom), 1'b1);
        check("midreset_accept", 32'(last_acc), 32'd1);
        drain("midreset_drain");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/skinny_inv_sbox_masked.md
Name: skinny_inv_sbox_masked

Overview:
- Two-share masked inverse of the SKINNY 4-bit S-box, used on the decryption datapath.
- Recombined output is S^-1(share0 ^ share1), with S^-1 = [3,4,6,8,c,a,1,e,9,2,5,7,0,b,d,f], indexed by the 4-bit value MSB-first.
- Built as a 4-stage registered pipeline: one NOR-XOR layer per stage, each with one domain-oriented AND gadget fed by one fresh random bit.
- A valid/ready handshake provides backpressure.

Parameters:
- OUT_REG, 0: when 1, adds an output register stage (latency 5 instead of 4).
- RND_W, 4: fresh random bits per evaluation, one per layer. Fixed at 4; any other value is a synthesis error.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  input shares and rnd are valid
- in_ready  out  1  pipeline can accept this cycle
- in_sh0  in  4  input share 0
- in_sh1  in  4  input share 1
- rnd  in  RND_W  fresh randomness, sampled with the input
- out_valid  out  1  output shares valid
- out_ready  in  1  downstream accepts this cycle
- out_sh0  out  4  output share 0
- out_sh1  out  4  output share 1

Behaviour:
- Reset (rst high at a clk edge):
  - All stage valid bits clear.
  - All share and rnd registers clear to 0.
  - out_valid = 0; out_sh0 = out_sh1 = 0.
  - in_ready = 1 in the cycle after reset.
  - Reset mid-operation discards all in-flight items with no output.
- Transfers:
  - Input transfer when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
- Stage k (k = 0..3):
  - Holds valid_k, sh0_k[3:0], sh1_k[3:0] and the not-yet-consumed rnd bits.
  - Stage k applies layer k using rnd[k].
  - rnd bits travel with their item; bit k is used only in stage k.
- Advance rule: stage k loads from stage k-1 when (!valid_k || advance_{k+1}), where advance_4 = out_ready.
- in_ready = !valid_0 || advance_1. This is combinational from out_ready through the pipeline; full-throughput bubble collapsing is required.
- A stalled stage holds its shares bit-exact. Registers are never rewritten with recombined or partially-recombined data.
- Latency: input accepted at edge t gives out_valid at edge t+4 (t+5 when OUT_REG=1), assuming no stalls.
- Throughput: one item per cycle when out_ready is held high.
- Layer function, unmasked:
  - Each layer computes x_j ^= NOR(x_p, x_q) followed by a fixed bit permutation.
  - The four layers compose exactly to S^-1.
- Layer function, masked:
  - NOR is computed as AND of complemented inputs; the complement is applied to share 0 only.
  - DOM AND: cross terms a0&b1 and a1&b0 are each XORed with rnd[k] before the register.
  - Inner terms a0&b0 and a1&b1 stay in their own domains.
  - Linear XOR and permutation are performed per share.
- Non-completeness: no register input may depend on both shares of the same variable except through a rnd-refreshed cross term.
- Simultaneous input and output transfer on a full pipeline is legal and keeps it full.
- out_sh0/out_sh1 are undefined-but-stable while out_valid = 0. The bench checks them only on transfer.

Decomposition:
- Package skinny_masked_pkg:
  - SHARE_W = 4.
  - Constant unmasked inverse table (reference model for assertions).
  - Layer index constants (j, p, q) and the per-layer bit permutation vectors.
- Sub-module: skinny_dom_and, a 2-share DOM AND with one random bit and registered output.
  - Instantiated once per layer.
  - Must carry an enable input so a stalled stage holds.

Test Plan:
- Reset then exhaustive sweep:
  - Stimulus: x = 0..15, in_sh1 = 0, rnd = 0, out_ready = 1.
  - Response: out_sh0 ^ out_sh1 = S^-1(x), e.g. x=0 -> 3, x=c -> 0, x=f -> f.
  - Timing: first out_valid exactly 4 cycles after first accept; then one result per cycle.
- Masked random run:
  - Stimulus: 10k items, random in_sh1 and rnd, x = in_sh0 ^ in_sh1.
  - Response: recombined output matches the table every time; out_sh1 is not constant across items with equal x.
- Backpressure:
  - Stimulus: out_ready low for 6 cycles with continuous in_valid.
  - Response: accepts 4 items (5 if OUT_REG=1), then in_ready = 0; shares in all stages unchanged during the stall.
  - On release, results come out in order with no loss or duplication.
- Full-pipe simultaneous transfer:
  - Stimulus: pipeline full, in_valid = out_ready = 1.
  - Response: in_ready = 1; one in and one out per cycle; occupancy stays 4.
- Reset mid-flight:
  - Stimulus: 3 items in flight, rst pulsed for 1 cycle.
  - Response: next cycle out_valid = 0 and out_sh0 = out_sh1 = 0; none of the 3 items ever appear; a new item emerges 4 cycles after its accept.
- Share-probe assertion: formal check that each register bit depends on at most one share index per input variable, rnd-refreshed cross terms excepted.
